// File: rtl/memoria_principal_ctrl_pkg.sv
// Shared constants, FSM state encoding and helpers for the main-memory controller.
package memoria_pkg;

    localparam int ADDR_W_DEF  = 5;
    localparam int DATA_W_DEF  = 3;
    localparam int LATENCY_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Statistics counters stick at their maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'd255) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/memoria_principal_ctrl_array.sv
// Word-addressed backing store: synchronous write, registered read port, and
// reset reloads every word with its own address (truncated to the word width).
module memoria_array
    import memoria_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              access,
    input  logic              we,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage update and read-port register; a write echoes its own data.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= DATA_W'(i);
            end
            rdata <= {DATA_W{1'b0}};
        end else if (access) begin
            if (we) begin
                mem_r[address] <= wdata;
                rdata          <= wdata;
            end else begin
                rdata <= mem_r[address];
            end
        end
    end

endmodule

// File: rtl/memoria_principal_ctrl.sv
// Slow main-memory controller behind the cache: single outstanding req/ack access
// with a fixed LATENCY wait. Optional MEM_STATS_EN adds saturating rd/wr counters.
module memoria_principal_ctrl
    import memoria_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
`ifdef MEM_STATS_EN
    output logic [7:0]        rd_count,
    output logic [7:0]        wr_count,
`endif
    output logic [DATA_W-1:0] rdata
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_latency_range
        $error("memoria_principal_ctrl: LATENCY must be in 1..15");
    end

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              access_s;

    // The array performs the access on the same edge that enters DONE.
    assign access_s = (state_r == WAIT) && (cnt_r == 4'd0);

    // Controller FSM with request latches, latency counter and registered busy/ack.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            busy    <= 1'b0;
            ack     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req) begin
                        we_r    <= we;
                        addr_r  <= address;
                        wdata_r <= wdata;
                        cnt_r   <= 4'(LATENCY - 1);
                        state_r <= WAIT;
                        busy    <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                    ack <= 1'b0;
                end
                WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        state_r <= DONE;
                        ack     <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    ack     <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    ack     <= 1'b0;
                end
            endcase
        end
    end

    memoria_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clock   (clock),
        .reset   (reset),
        .access  (access_s),
        .we      (we_r),
        .address (addr_r),
        .wdata   (wdata_r),
        .rdata   (rdata)
    );

`ifdef MEM_STATS_EN
    // Completed-access statistics, counted on the WAIT to DONE edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_count <= 8'd0;
            wr_count <= 8'd0;
        end else if (access_s) begin
            if (we_r) begin
                wr_count <= sat_inc8(wr_count);
            end else begin
                rd_count <= sat_inc8(rd_count);
            end
        end
    end
`endif

endmodule
